// File: rtl/sipo_rx_pkg.sv
// rtl/sipo_rx_pkg.sv - shared types and constants for the SIPO frame receiver
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    localparam int   DEF_WIDTH = 4;
    localparam logic START_LVL = 1'b1;

endpackage

// File: rtl/sipo_shreg.sv
// rtl/sipo_shreg.sv - WIDTH-bit right-shift register, LSB-first assembly with sync clear
module sipo_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // New bits enter at the MSB so the first bit received ends up in bit 0
    assign next_o = {sin_i, sr_q[WIDTH-1:1]};
    assign q_o    = sr_q;

    // Clear has priority over shift; otherwise hold
    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (shift_i) begin
            sr_d = next_o;
        end
    end

    // Shift register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - serial frame receiver with valid/ready output; SIPO_FRAME_RX_PARITY_EN adds even parity
module sipo_frame_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    rx_state_t        state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             overrun_q;
    logic             par_err_q;

    logic [WIDTH-1:0] sr_next;
    logic             start_hit;
    logic             shift_en;
    logic             last_data;
    logic             out_free;
    logic             deliver_req;
    logic             par_bad;
    logic [WIDTH-1:0] deliver_word;

    assign start_hit = (state_q == IDLE) && sin_en && (sin == START_LVL);
    assign shift_en  = (state_q == SHIFT) && sin_en;
    assign last_data = shift_en && (cnt_q == LAST_IDX);
    // A word consumed on the same edge frees the slot for the incoming frame
    assign out_free  = !out_valid_q || out_ready;

`ifdef SIPO_FRAME_RX_PARITY_EN
    logic [WIDTH-1:0] sr_q;

    sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_hit),
        .shift_i(shift_en),
        .sin_i  (sin),
        .q_o    (sr_q),
        .next_o (sr_next)
    );

    // Frame ends on the parity strobe; even parity over data plus parity bit
    always_comb begin
        deliver_req  = 1'b0;
        par_bad      = 1'b0;
        deliver_word = sr_q;
        if ((state_q == PARITY) && sin_en) begin
            if ((^sr_q) ^ sin) begin
                par_bad = 1'b1;
            end else begin
                deliver_req = 1'b1;
            end
        end
    end
`else
    sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_hit),
        .shift_i(shift_en),
        .sin_i  (sin),
        .q_o    (),
        .next_o (sr_next)
    );

    // Frame ends on the last data strobe; the word includes the bit being sampled
    always_comb begin
        deliver_req  = last_data;
        par_bad      = 1'b0;
        deliver_word = sr_next;
    end
`endif

    // Receive FSM, bit counter, output register and one-cycle status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            par_err_q <= par_bad;

            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (deliver_req) begin
                if (out_free) begin
                    out_data_q  <= deliver_word;
                    out_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_hit) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (last_data) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef SIPO_FRAME_RX_PARITY_EN
                PARITY: begin
                    if (sin_en) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign par_err   = par_err_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - directed self-checking bench for sipo_frame_rx
module tb_sipo_frame_rx;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         sin;
    logic         sin_en;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;
    logic         par_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] got_q[$];

    sipo_frame_rx #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (sin),
        .sin_en   (sin_en),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .overrun  (overrun),
        .par_err  (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sin    = b;
        sin_en = 1'b1;
        @(posedge clk);
        #1;
        sin_en = 1'b0;
        sin    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sin_en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, data LSB first, optional parity; random idle gaps inside the frame
    task automatic send_frame(input logic [W-1:0] d, input logic bad_par, input int max_gap);
        logic p;
        p = (^d) ^ bad_par;
        send_bit(1'b1);
        for (int i = 0; i < W; i++) begin
            if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
            send_bit(d[i]);
        end
`ifdef SIPO_FRAME_RX_PARITY_EN
        if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
        send_bit(p);
`else
        if (p === 1'bx) $display("note: unknown parity");
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        sin       = 1'b1;
        sin_en    = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);

        // Release with start bit already on the line: next strobe starts a frame
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sin_en = 1'b0;
        check("start_busy", 32'(busy), 32'h1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("pre_last_valid", 32'(out_valid), 32'h0);
        send_bit(1'b1);
`ifdef SIPO_FRAME_RX_PARITY_EN
        check("pre_par_valid", 32'(out_valid), 32'h0);
        send_bit(1'b1);
`endif
        check("basic_valid", 32'(out_valid), 32'h1);
        check("basic_data", 32'(out_data), 32'hE);
        check("basic_idle", 32'(busy), 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("consume_valid", 32'(out_valid), 32'h0);
        check("consume_hold", 32'(out_data), 32'hE);

        // Back-to-back frames with gaps inside frames, consumer always ready
        got_q.delete();
        out_ready = 1'b1;
        send_frame(4'hA, 1'b0, 2);
        send_bit(1'b1);
        check("b2b_start_busy", 32'(busy), 32'h1);
        for (int i = 0; i < W; i++) begin
            idle_cycles($urandom_range(0, 2));
            send_bit(i[0] ? 1'b0 : 1'b1);
        end
`ifdef SIPO_FRAME_RX_PARITY_EN
        send_bit(1'b0);
`endif
        idle_cycles(2);
        check("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            check("b2b_word0", 32'(got_q[0]), 32'hA);
            check("b2b_word1", 32'(got_q[1]), 32'h5);
        end

        // Overrun: hold the first word while a second frame completes
        out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 0);
        check("ovr_first_valid", 32'(out_valid), 32'h1);
        check("ovr_first_data", 32'(out_data), 32'h3);
        check("ovr_first_flag", 32'(overrun), 32'h0);
        send_frame(4'hC, 1'b0, 1);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_keep_data", 32'(out_data), 32'h3);
        check("ovr_keep_valid", 32'(out_valid), 32'h1);
        idle_cycles(1);
        check("ovr_one_cycle", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        idle_cycles(1);
        out_ready = 1'b0;
        check("ovr_drain", 32'(out_valid), 32'h0);

`ifdef SIPO_FRAME_RX_PARITY_EN
        // 4'b1110 has odd weight: parity 1 is correct, parity 0 is an error
        send_frame(4'hE, 1'b1, 0);
        check("par_bad_pulse", 32'(par_err), 32'h1);
        check("par_bad_valid", 32'(out_valid), 32'h0);
        check("par_bad_ovr", 32'(overrun), 32'h0);
        idle_cycles(1);
        check("par_one_cycle", 32'(par_err), 32'h0);
        send_frame(4'hE, 1'b0, 0);
        check("par_ok_err", 32'(par_err), 32'h0);
        check("par_ok_valid", 32'(out_valid), 32'h1);
        check("par_ok_data", 32'(out_data), 32'hE);
        out_ready = 1'b1;
        idle_cycles(1);
        out_ready = 1'b0;
`endif

        // Reset partway through a frame, then a clean frame
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_flags", 32'({overrun, par_err, out_valid}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(4'h9, 1'b0, 1);
        check("midrst_valid", 32'(out_valid), 32'h1);
        check("midrst_data", 32'(out_data), 32'h9);
        check("midrst_noovr", 32'(overrun), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
